// File: rtl/motion_search_ctrl.sv
// Full-search motion estimation sequencer for one macroblock.
// Ports: start/abort control, cmp_* compare handshake, cand_* fetch, best_* result.
module motion_search_ctrl #(
  parameter int RANGE = 7,
  parameter int ACC_W = 18
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [4:0]       cand_x,
  output logic [4:0]       cand_y,
  output logic             cmp_en,
  input  logic             cmp_rdy,
  input  logic             cmp_valid,
  input  logic [ACC_W-1:0] cmp_accum,
  output logic [ACC_W-1:0] cmp_oldaccum,
  output logic [4:0]       best_x,
  output logic [4:0]       best_y,
  output logic [ACC_W-1:0] best_sad,
  output logic             best_found
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    NEXT,
    DONE
  } state_t;

  localparam logic [4:0] POS = 5'(RANGE);
  localparam logic [4:0] NEG = 5'(-RANGE);

  state_t state;
  logic   last;

  assign last = (cand_x == POS) && (cand_y == POS);

  // An abort in the same cycle must not launch a compare.
  assign cmp_en = (state == ISSUE) && cmp_rdy && !abort;

  // Threshold one below the best makes an equal SAD prune,
  // so the earliest candidate in raster order keeps a tie.
  assign cmp_oldaccum = best_found ? best_sad - ACC_W'(1)
                                   : best_sad;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      cand_x     <= '0;
      cand_y     <= '0;
      best_x     <= '0;
      best_y     <= '0;
      best_sad   <= '1;
      best_found <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state      <= ISSUE;
            busy       <= 1'b1;
            cand_x     <= NEG;
            cand_y     <= NEG;
            best_x     <= '0;
            best_y     <= '0;
            best_sad   <= '1;
            best_found <= 1'b0;
          end
        end
        ISSUE: begin
          if (cmp_rdy) state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!cmp_rdy) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (cmp_rdy) begin
            if (cmp_valid) begin
              best_sad   <= cmp_accum;
              best_x     <= cand_x;
              best_y     <= cand_y;
              best_found <= 1'b1;
            end
            if (last) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= NEXT;
            end
          end
        end
        NEXT: begin
          state <= ISSUE;
          if (cand_x == POS) begin
            cand_x <= NEG;
            cand_y <= cand_y + 5'd1;
          end else begin
            cand_x <= cand_x + 5'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_motion_search_ctrl.sv
// Self-checking bench for motion_search_ctrl with a compare-unit model.
// Expected candidates, thresholds and winners come from a search-level model.
module tb_motion_search_ctrl;

  localparam int R     = 1;
  localparam int W     = 2*R+1;
  localparam int N     = W*W;
  localparam int ACC_W = 18;
  localparam logic [ACC_W-1:0] ONES = '1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             busy, done, cmp_en;
  logic             cmp_rdy, cmp_valid;
  logic [4:0]       cand_x, cand_y, best_x, best_y;
  logic [ACC_W-1:0] cmp_accum, cmp_oldaccum, best_sad;
  logic             best_found;

  motion_search_ctrl #(.RANGE(R), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .cand_x(cand_x), .cand_y(cand_y),
    .cmp_en(cmp_en), .cmp_rdy(cmp_rdy), .cmp_valid(cmp_valid),
    .cmp_accum(cmp_accum), .cmp_oldaccum(cmp_oldaccum),
    .best_x(best_x), .best_y(best_y), .best_sad(best_sad),
    .best_found(best_found)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [ACC_W-1:0] sad_tab [N];
  logic [ACC_W-1:0] thr_at [N];
  bit never_valid = 0;
  bit slow = 0;
  int k = 0;
  int done_cnt = 0;
  int force_low = 0;
  int rdy_rise_cyc = -1;
  int first_en_cyc = -1;
  int ph = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [4:0] kx(input int i);
    return 5'(i % W - R);
  endfunction

  function automatic logic [4:0] ky(input int i);
    return 5'(i / W - R);
  endfunction

  // earliest strict minimum over candidates [0, upto)
  function automatic int best_idx(input int upto);
    int b = -1;
    for (int i = 0; i < upto; i++)
      if (b < 0 || sad_tab[i] < sad_tab[b]) b = i;
    return b;
  endfunction

  function automatic logic [ACC_W-1:0] exp_thr(input int i);
    int b = best_idx(i);
    if (never_valid || b < 0) return ONES;
    return sad_tab[b] - ACC_W'(1);
  endfunction

  // compare process: every issued compare and every done pulse
  always @(negedge clk) begin
    if (reset_n) begin
      if (cmp_en) begin
        if (k < N) begin
          chk("en_cand_x", 32'(cand_x), 32'(kx(k)));
          chk("en_cand_y", 32'(cand_y), 32'(ky(k)));
          chk("en_thr", 32'(cmp_oldaccum), 32'(exp_thr(k)));
          chk("en_busy", 32'(busy), 32'd1);
          thr_at[k] = cmp_oldaccum;
        end else begin
          chk("en_overrun", 32'(k), 32'(N - 1));
        end
        if (k == 0 && first_en_cyc < 0) first_en_cyc = cyc;
        k++;
      end
      if (done) begin
        int b;
        done_cnt++;
        b = best_idx(N);
        chk("done_en_count", 32'(k), 32'(N));
        chk("done_busy", 32'(busy), 32'd0);
        if (never_valid) begin
          chk("done_found", 32'(best_found), 32'd0);
          chk("done_sad", 32'(best_sad), 32'(ONES));
          chk("done_x", 32'(best_x), 32'd0);
          chk("done_y", 32'(best_y), 32'd0);
        end else begin
          chk("done_found", 32'(best_found), 32'd1);
          chk("done_sad", 32'(best_sad), 32'(sad_tab[b]));
          chk("done_x", 32'(best_x), 32'(kx(b)));
          chk("done_y", 32'(best_y), 32'(ky(b)));
        end
      end
    end
  end

  // compare unit model: optional slow drop of rdy, 1..3 busy cycles
  initial begin : unit
    logic en_n;
    logic [4:0] ux, uy, cx, cy;
    logic [ACC_W-1:0] uth, th;
    logic prev_rdy;
    int pre, lat, idx;
    cmp_rdy   = 1'b1;
    cmp_valid = 1'b0;
    cmp_accum = '0;
    pre = 0; lat = 0; ux = '0; uy = '0; uth = '0;
    forever begin
      @(negedge clk);
      en_n = cmp_en & reset_n;
      cx = cand_x; cy = cand_y; th = cmp_oldaccum;
      @(posedge clk); #1;
      prev_rdy = cmp_rdy;
      if (force_low > 0) force_low--;
      if (ph == 0 && en_n) begin
        ux = cx; uy = cy; uth = th;
        pre = slow ? int'($urandom_range(0, 2)) : 0;
        lat = int'($urandom_range(1, 3));
        ph  = (pre > 0) ? 1 : 2;
      end else if (ph == 1) begin
        pre--;
        if (pre == 0) ph = 2;
      end else if (ph == 2) begin
        lat--;
        if (lat == 0) begin
          ph = 0;
          idx = (int'($signed(uy)) + R) * W + (int'($signed(ux)) + R);
          cmp_accum = (idx >= 0 && idx < N) ? sad_tab[idx] : ONES;
          cmp_valid = never_valid ? 1'b0 : (cmp_accum <= uth);
          if (busy) begin
            chk("hold_x", 32'(cand_x), 32'(ux));
            chk("hold_y", 32'(cand_y), 32'(uy));
          end
        end
      end
      cmp_rdy = (ph == 1) || (ph == 0 && force_low == 0);
      if (cmp_rdy && !prev_rdy && rdy_rise_cyc < 0) rdy_rise_cyc = cyc;
    end
  end

  task automatic do_start(input int hold_low);
    @(posedge clk); #2;
    k = 0;
    first_en_cyc = -1;
    rdy_rise_cyc = -1;
    force_low = hold_low;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == d0) chk({nm, "_timeout"}, 32'd0, 32'd1);
    repeat (3) @(posedge clk);
    chk({nm, "_done_once"}, 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic wait_k(input int target);
    int n = 0;
    while (k < target && n < 1000) begin
      @(posedge clk);
      n++;
    end
    if (k < target) chk("wait_k_timeout", 32'(k), 32'(target));
  endtask

  task automatic wait_unit_idle();
    int n = 0;
    while (ph != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #2;
  endtask

  task automatic rand_table(input int hi);
    for (int i = 0; i < N; i++)
      sad_tab[i] = ACC_W'($urandom_range(1, hi));
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int d0, k0;
    for (int i = 0; i < N; i++) sad_tab[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cmp_en", 32'(cmp_en), 32'd0);
    chk("rst_best_sad", 32'(best_sad), 32'h3FFFF);
    chk("rst_found", 32'(best_found), 32'd0);
    chk("rst_cand_x", 32'(cand_x), 32'd0);
    chk("rst_best_y", 32'(best_y), 32'd0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // known table, minimum 100 at (+1,-1)
    sad_tab = '{200, 300, 100, 400, 500, 600, 700, 800, 900};
    do_start(0);
    wait_done("r1");
    chk("r1_en_pulses", 32'(k), 32'd9);
    chk("r1_best_x", 32'(best_x), 32'h01);
    chk("r1_best_y", 32'(best_y), 32'h1F);
    chk("r1_best_sad", 32'(best_sad), 32'd100);
    chk("r1_thr0", 32'(thr_at[0]), 32'h3FFFF);
    chk("r1_thr1", 32'(thr_at[1]), 32'd199);
    chk("r1_thr3", 32'(thr_at[3]), 32'd99);

    // equal SADs: earliest candidate keeps the win
    sad_tab = '{50, 80, 80, 80, 50, 80, 80, 80, 80};
    do_start(0);
    wait_done("tie");
    chk("tie_best_x", 32'(best_x), 32'h1F);
    chk("tie_best_y", 32'(best_y), 32'h1F);
    chk("tie_best_sad", 32'(best_sad), 32'd50);
    chk("tie_thr1", 32'(thr_at[1]), 32'd49);
    chk("tie_thr4", 32'(thr_at[4]), 32'd49);
    chk("tie_thr8", 32'(thr_at[8]), 32'd49);

    // every candidate pruned
    rand_table(300);
    never_valid = 1;
    do_start(0);
    wait_done("prune");
    chk("prune_found", 32'(best_found), 32'd0);
    chk("prune_sad", 32'(best_sad), 32'h3FFFF);
    chk("prune_x", 32'(best_x), 32'd0);
    never_valid = 0;

    // ready held low after start, stray start while busy
    rand_table(300);
    slow = 1;
    do_start(6);
    wait_k(4);
    @(posedge clk); #2;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done("bp");
    chk("bp_rise_seen", 32'(rdy_rise_cyc >= 0), 32'd1);
    chk("bp_first_en", 32'(first_en_cyc), 32'(rdy_rise_cyc));
    slow = 0;

    // abort during candidate 4
    wait_unit_idle();
    rand_table(300);
    do_start(0);
    wait_k(5);
    #2;
    abort = 1'b1;
    @(posedge clk); #2;
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_found", 32'(best_found), 32'd1);
    chk("abort_sad", 32'(best_sad), 32'(sad_tab[best_idx(4)]));
    chk("abort_x", 32'(best_x), 32'(kx(best_idx(4))));
    chk("abort_y", 32'(best_y), 32'(ky(best_idx(4))));
    d0 = done_cnt;
    k0 = k;
    repeat (10) @(posedge clk);
    chk("abort_no_done", 32'(done_cnt), 32'(d0));
    chk("abort_no_en", 32'(k), 32'(k0));
    wait_unit_idle();
    do_start(0);
    @(negedge clk);
    chk("restart_sad", 32'(best_sad), 32'h3FFFF);
    chk("restart_found", 32'(best_found), 32'd0);
    chk("restart_x", 32'(cand_x), 32'h1F);
    chk("restart_y", 32'(cand_y), 32'h1F);
    wait_done("restart");

    // randomized searches, narrow SAD range to provoke ties
    for (int r = 0; r < 6; r++) begin
      wait_unit_idle();
      rand_table((r % 2 == 0) ? 20 : 5000);
      slow = bit'($urandom_range(0, 1));
      do_start(int'($urandom_range(0, 3)));
      wait_done("rand");
    end
    slow = 0;

    // asynchronous reset in the middle of a search
    wait_unit_idle();
    rand_table(300);
    do_start(0);
    wait_k(3);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_cmp_en", 32'(cmp_en), 32'd0);
    chk("arst_best_sad", 32'(best_sad), 32'h3FFFF);
    chk("arst_found", 32'(best_found), 32'd0);
    chk("arst_cand_x", 32'(cand_x), 32'd0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    repeat (5) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
